// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
//   arb_state_t : arbiter FSM states
//   onehot()    : index -> one-hot vector (callers truncate to their width)
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned ONEHOT_W = 32;

    // Wide one-hot; callers cast down to their own request width.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin picker: returns the first set bit of req strictly after
// position 'last', wrapping around. Purely combinational.
//   req   in   N          request vector
//   last  in   clog2(N)   previous winner
//   idx   out  clog2(N)   selected index (valid when found)
//   found out  1          at least one request present
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int unsigned LW = $clog2(N);

    logic [LW-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest requester after
    // 'last' is the one left standing.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = int'(N); k >= 1; k--) begin
            pos = LW'((int'(last) + k) % int'(N));
            if (req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares the async FIFO read port among NUM_REQ read-domain consumers with
// round-robin grants and bursts of at most MAX_BURST pops.
//   r_clk, r_rst       clock, synchronous active-high reset
//   req, rdy           per-consumer request / can-accept
//   fifo_r_empty/data  FIFO read side inputs
//   fifo_r_en          FIFO read enable (combinational, independent of empty)
//   out_data           FIFO data pass-through
//   out_valid          one-hot word strobe to the owning consumer (combinational)
//   grant              registered one-hot owner, 0 when idle
//   busy               registered, high while a burst is in progress
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               r_clk,
    input  logic               r_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rdy,
    input  logic               fifo_r_empty,
    input  logic [DSIZE-1:0]   fifo_r_data,
    output logic               fifo_r_en,
    output logic [DSIZE-1:0]   out_data,
    output logic [NUM_REQ-1:0] out_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               busy_q,  busy_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               pop;
    logic               owner_req;
    logic               burst_done;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Read-side decode; enable depends only on owner req/rdy, never on empty.
    always_comb begin
        fifo_r_en = 1'b0;
        if (!r_rst && state_q == ARB_BURST) begin
            fifo_r_en = |(grant_q & req & rdy);
        end
        pop       = fifo_r_en & ~fifo_r_empty;
        out_valid = grant_q & {NUM_REQ{pop}};
        out_data  = fifo_r_data;
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        owner_req  = |(grant_q & req);
        burst_done = pop && (cnt_q == CNT_W'(MAX_BURST - 1));

        case (state_q)
            ARB_IDLE: begin
                if (!fifo_r_empty && pick_found) begin
                    state_d = ARB_BURST;
                    grant_d = NUM_REQ'(onehot(32'(pick_idx)));
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_BURST: begin
                // Burst completion, owner withdrawal and empty all end the grant;
                // a pop in the same cycle still completes.
                if (burst_done || !owner_req || fifo_r_empty) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (pop) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ARB_BURST);
    end

    // State registers; last winner resets to NUM_REQ-1 so req[0] leads.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus random traffic against a
// burst-level ownership model, with a scoreboard of expected deliveries.
module tb_fifo_rd_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 8;

    logic          r_clk;
    logic          r_rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  rdy = '0;
    logic          fifo_r_empty = 1'b1;
    logic [DW-1:0] fifo_r_data = '0;
    logic          fifo_r_en;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  grant;
    logic          busy;

    fifo_rd_arbiter #(.NUM_REQ(N), .DSIZE(DW), .MAX_BURST(MB)) dut (
        .r_clk        (r_clk),
        .r_rst        (r_rst),
        .req          (req),
        .rdy          (rdy),
        .fifo_r_empty (fifo_r_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_en    (fifo_r_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .grant        (grant),
        .busy         (busy)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [DW-1:0] d;
        int            who;
    } exp_t;

    logic [DW-1:0] wq[$];      // contents of the modelled FIFO
    exp_t          exp_q[$];   // expected deliveries
    int            total = 0;
    int            bad   = 0;

    // Ownership model: who holds the port, who won last, pops in this burst.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_cnt   = 0;

    // Burst trace for directed checks.
    int     gseq[$];
    int     pulses[$];
    int     bpops = 0;
    int     prev_grant = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // One clock cycle: drive at negedge, check, advance model.
    task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] rd,
                       input logic rs, input int npush);
        logic exp_en;
        logic exp_pop;
        int   pick;
        @(negedge r_clk);
        repeat (npush) wq.push_back(DW'($urandom));
        req          = rq;
        rdy          = rd;
        r_rst        = rs;
        fifo_r_empty = (wq.size() == 0);
        fifo_r_data  = fifo_r_empty ? DW'($urandom) : wq[0];
        #1;
        exp_en  = !rs && m_owner >= 0 && rq[m_owner] && rd[m_owner];
        exp_pop = exp_en && !fifo_r_empty;
        chk("grant", int'(grant), m_owner >= 0 ? (1 << m_owner) : 0);
        chk("busy", int'(busy), m_owner >= 0 ? 1 : 0);
        chk("fifo_r_en", int'(fifo_r_en), int'(exp_en));
        chk("out_valid", int'(out_valid), exp_pop ? (1 << m_owner) : 0);
        chk("out_data", int'(out_data), int'(fifo_r_data));
        if (exp_pop) exp_q.push_back('{fifo_r_data, m_owner});

        if (prev_grant == 0 && grant != 0) gseq.push_back(int'(grant));
        if (grant != 0 && fifo_r_en && !fifo_r_empty) bpops++;
        if (prev_grant != 0 && grant == 0) begin
            pulses.push_back(bpops);
            bpops = 0;
        end
        prev_grant = int'(grant);

        // The FIFO loses its head word whenever the DUT actually pops.
        if (fifo_r_en && !fifo_r_empty) void'(wq.pop_front());

        if (rs) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (!fifo_r_empty && rq != 0) begin
                pick = -1;
                for (int k = 1; k <= int'(N); k++) begin
                    int c;
                    c = (m_last + k) % int'(N);
                    if (pick < 0 && rq[c]) pick = c;
                end
                m_owner = pick;
                m_last  = pick;
                m_cnt   = 0;
            end
        end else begin
            if (exp_pop) m_cnt++;
            if ((exp_pop && m_cnt == int'(MB)) || !rq[m_owner] || fifo_r_empty) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic start_test();
        wq.delete();
        cyc('0, '0, 1'b1, 0);
        cyc('0, '0, 1'b1, 0);
        gseq.delete();
        pulses.delete();
        bpops = 0;
    endtask

    // Delivery monitor: every strobe must match the next expected word/consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge r_clk);
            #2;
            if (out_valid != '0) begin
                chk("ov_onehot", int'($onehot(out_valid)), 1);
                if (exp_q.size() == 0) begin
                    chk("sb_spurious", int'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", int'(out_data), int'(e.d));
                    chk("sb_dest", int'(out_valid), 1 << e.who);
                end
            end
        end
    end

    initial begin
        int exp_g[5];
        logic [N-1:0] rq, rd;

        // T1: reset mid-burst, then first grant goes to consumer 0
        start_test();
        cyc(4'b1111, 4'b1111, 1'b0, 4);
        repeat (4) cyc(4'b1111, 4'b1111, 1'b0, 1);
        cyc(4'b1111, 4'b1111, 1'b1, 1);
        cyc(4'b1111, 4'b1111, 1'b0, 1);
        chk("t1_grant_after_rst", int'(grant), 0);
        chk("t1_busy_after_rst", int'(busy), 0);
        gseq.delete();
        repeat (3) cyc(4'b1111, 4'b1111, 1'b0, 1);
        chk("t1_first_grant", q_at(gseq, 0), 1);

        // T2: round-robin, full bursts
        start_test();
        cyc(4'b1111, 4'b1111, 1'b0, 4);
        repeat (45) cyc(4'b1111, 4'b1111, 1'b0, 1);
        exp_g = '{1, 2, 4, 8, 1};
        for (int i = 0; i < 5; i++) chk("t2_grant_seq", q_at(gseq, i), exp_g[i]);
        for (int i = 0; i < 4; i++) chk("t2_burst_len", q_at(pulses, i), int'(MB));

        // T3: FIFO runs dry mid-burst
        start_test();
        cyc(4'b0100, 4'b1111, 1'b0, 3);
        repeat (8) cyc(4'b0100, 4'b1111, 1'b0, 0);
        chk("t3_pops", q_at(pulses, 0), 3);
        chk("t3_no_regrant", gseq.size(), 1);
        cyc(4'b0100, 4'b1111, 1'b0, 1);
        repeat (3) cyc(4'b0100, 4'b1111, 1'b0, 0);
        chk("t3_regrant", q_at(gseq, 1), 4);

        // T4: owner stalls on rdy
        start_test();
        cyc(4'b0010, 4'b1111, 1'b0, 4);
        repeat (3) cyc(4'b0010, 4'b1111, 1'b0, 1);
        repeat (5) cyc(4'b0010, 4'b1101, 1'b0, 1);
        chk("t4_stall_grant", int'(grant), 2);
        chk("t4_stall_en", int'(fifo_r_en), 0);
        repeat (8) cyc(4'b0010, 4'b1111, 1'b0, 1);
        chk("t4_burst_len", q_at(pulses, 0), int'(MB));

        // T5: owner drops req after 2 pops; next grant wraps to 0
        start_test();
        cyc(4'b1000, 4'b1111, 1'b0, 4);
        repeat (2) cyc(4'b1000, 4'b1111, 1'b0, 1);
        repeat (4) cyc(4'b0011, 4'b1111, 1'b0, 1);
        chk("t5_first", q_at(gseq, 0), 8);
        chk("t5_pops", q_at(pulses, 0), 2);
        chk("t5_next", q_at(gseq, 1), 1);

        // T6: random traffic
        start_test();
        repeat (2000) begin
            rq = ($urandom_range(3) == 0) ? 4'b1111 : N'($urandom);
            rd = N'($urandom) | N'($urandom);
            cyc(rq, rd, ($urandom_range(149) == 0), ($urandom_range(2) == 0) ? 1 : 0);
        end
        repeat (3) cyc('0, '0, 1'b0, 0);
        #5;
        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
